lt_comparator: RTL and testbench

Registered 32-bit "less than" comparator for the integer math component library. Each cycle it compares operands `a` and `b` and registers the 1-bit result `z` = (a < b). It is a leaf arithmetic component used directly by generated datapaths and by the stimulus-file regression flow, which samples `z` on every rising clock edge.

---
 rtl/lt_comparator.sv | 83 ++++++++
 tb/tb_lt_comparator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/lt_comparator.sv
// Registered WIDTH-bit "less than" comparator (z = a < b, signed or unsigned) built as a log-depth 4-bit group tree.
// Optional macro LT_INPUT_REG_EN adds a reset-to-zero input register stage (latency 2 instead of 1).
module lt_comparator #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             z,
    input  logic             rst
);

    localparam int GROUPS = (WIDTH + 3) / 4;
    localparam int LEVELS = (GROUPS > 1) ? $clog2(GROUPS) : 0;
    localparam int LEAVES = 1 << LEVELS;
    localparam int NODES  = 2 * LEAVES - 1;
    localparam int PW     = GROUPS * 4;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;

`ifdef LT_INPUT_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign a_cmp = a_q;
    assign b_cmp = b_q;
`else
    assign a_cmp = a;
    assign b_cmp = b;
`endif

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;

    // Zero-extension of the top group happens after the sign-bit flip.
    assign a_ext = PW'(a_cmp ^ MSB_FLIP);
    assign b_ext = PW'(b_cmp ^ MSB_FLIP);

    // Heap-ordered tree: node i has low child 2i+1 and high child 2i+2, leaves start at LEAVES-1.
    logic [NODES-1:0] lt_node;
    logic [NODES-1:0] eq_node;

    for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
        if (g < GROUPS) begin : g_real
            assign lt_node[LEAVES-1+g] = a_ext[4*g +: 4] <  b_ext[4*g +: 4];
            assign eq_node[LEAVES-1+g] = a_ext[4*g +: 4] == b_ext[4*g +: 4];
        end else begin : g_pad
            // Padding groups sit above the real ones and compare as equal, so they never decide.
            assign lt_node[LEAVES-1+g] = 1'b0;
            assign eq_node[LEAVES-1+g] = 1'b1;
        end
    end

    for (genvar i = 0; i < LEAVES - 1; i++) begin : g_merge
        assign lt_node[i] = lt_node[2*i+2] | (eq_node[2*i+2] & lt_node[2*i+1]);
        assign eq_node[i] = eq_node[2*i+2] & eq_node[2*i+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            z <= lt_node[0] & ~eq_node[0];
        end
    end

endmodule

// File: tb/tb_lt_comparator.sv
// Scoreboard bench for lt_comparator: signed and unsigned instances share stimulus; latency follows LT_INPUT_REG_EN.
module tb_lt_comparator;

`ifdef LT_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int unsigned issue;
        logic        exp_s;
        logic        exp_u;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        z_s;
    logic        z_u;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    lt_comparator #(.WIDTH(32), .SIGNED(1)) dut_s (.clk(clk), .a(a), .b(b), .z(z_s), .rst(rst));
    lt_comparator #(.WIDTH(32), .SIGNED(0)) dut_u (.clk(clk), .a(a), .b(b), .z(z_u), .rst(rst));

    always #5 clk = ~clk;

    // Directed vectors: operands and hand-computed signed / unsigned results.
    logic [31:0] dir_a [13] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1234,
                                32'h0001_0000, 32'h0000_0005, 32'h8000_0005, 32'h1234_5678,
                                32'h1234_5679, 32'hFFFF_FFFE, 32'h0000_000F, 32'hFFFF_FFFF};
    logic [31:0] dir_b [13] = '{32'd1, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1234,
                                32'h0001_0001, 32'h8000_0005, 32'h0000_0005, 32'h1234_5679,
                                32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_FFFF};
    logic        dir_s [13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        dir_u [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic es, input logic eu);
        @(negedge clk);
        a = va;
        b = vb;
        sb_q.push_back('{issue: cyc + 1, exp_s: es, exp_u: eu});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_async_s", z_s, 1'b0);
        check("midrst_async_u", z_u, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_hold_s", z_s, 1'b0);
        check("midrst_hold_u", z_u, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: the result for inputs captured at edge n is visible after edge n+LAT-1.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb_q.size() > 0 && sb_q[0].issue + LAT - 1 <= cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                check("z_signed", z_s, e.exp_s);
                check("z_unsigned", z_u, e.exp_u);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1;
        a   = 32'd5;
        b   = 32'd9;
        #1;
        check("reset_async_s", z_s, 1'b0);
        check("reset_async_u", z_u, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold_s", z_s, 1'b0);
            check("reset_hold_u", z_u, 1'b0);
        end

        // Release with a=5, b=9 held: z rises one latency period later.
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{issue: cyc + 1, exp_s: 1'b1, exp_u: 1'b1});

        for (int i = 0; i < 13; i++) begin
            drive(dir_a[i], dir_b[i], dir_s[i], dir_u[i]);
        end

        for (int i = 0; i < 450; i++) begin
            if (i == 200) begin
                drive(32'd0, 32'd1, 1'b1, 1'b1);
                drive(32'd0, 32'd1, 1'b1, 1'b1);
                pulse_reset();
            end
            ra = $urandom();
            rb = (i % 37 == 0) ? ra : $urandom();
            drive(ra, rb, $signed(ra) < $signed(rb), ra < rb);
        end

        repeat (LAT + 2) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
